fifo_burst_ctrl: RTL and testbench
==================================

// Module: fifo_burst_ctrl
// PURPOSE
// - Pointer/flag controller and burst read scheduler for a 2**SIZE-entry FIFO built on external sync-read RAM.
// - Owns the write and read pointers and drives RAM write/read strobes and addresses.
// - Produces full/empty/count plus parameterised almost-empty/almost-full thresholds.
// - Drains the FIFO to a downstream consumer in fixed BURST-length valid/ready bursts.
// PARAMETERS
// - SIZE      4   address width; DEPTH = 2**SIZE entries
// - BURST     4   beats per read burst; 1..DEPTH
// - AE_THRESH 10  ae_flag=1 while count < AE_THRESH; 0..DEPTH
// - AF_THRESH 12  af_flag=1 while count >= AF_THRESH; 1..DEPTH
// PORTS
// - clk        in   1       rising-edge clock
// - rst_n      in   1       async active-low reset
// - wr_req     in   1       upstream write request
// - wr_accept  out  1       = wr_req & ~full (comb); word written this cycle
// - ram_we     out  1       RAM write enable (= wr_accept)
// - ram_waddr  out  SIZE    = wptr[SIZE-1:0]
// - ram_re     out  1       RAM read enable; data valid on RAM output next cycle
// - ram_raddr  out  SIZE    = rptr[SIZE-1:0]
// - rd_valid   out  1       RAM output word is valid for consumer
// - rd_ready   in   1       consumer accepts word when rd_valid & rd_ready
// - rd_last    out  1       qualifies final beat of a burst (with rd_valid)
// - flush      in   1       1-cycle pulse: drain all resident data, short bursts allowed
// - full/empty out  1       count==DEPTH / count==0
// - ae_flag    out  1       almost empty
// - af_flag    out  1       almost full
// - count      out  SIZE+1  occupancy, 0..DEPTH
// BEHAVIOUR
// - Reset (async, rst_n=0): wptr=rptr=0, FSM=IDLE, beat_cnt=0, flush_pend=0.
//   Reset values: rd_valid=0, rd_last=0, ram_re=0, count=0, empty=1, full=0, ae_flag=(AE_THRESH>0), af_flag=0.
//   A reset mid-burst discards the burst; no further beats are presented.
// - Pointers are SIZE+1 bits and wrap naturally. count = wptr - rptr, modulo 2**(SIZE+1).
//   All flags decode combinationally from registered pointers.
// - Write path: wptr increments on each accepted write. While full, wr_req is ignored (no bypass), even if a read retires the same cycle.
// - Simultaneous write accept and read retire: both pointers move; count is unchanged next cycle.
// - FSM (3 states):
//   - IDLE: if count>=BURST, load beat_cnt=BURST and go FETCH.
//     Else if flush_pend & count>0, load beat_cnt=count and go FETCH.
//     Else if flush_pend & count==0, clear flush_pend.
//   - FETCH: ram_re=1 for 1 cycle at ram_raddr=rptr[SIZE-1:0]; go HOLD.
//   - HOLD: rd_valid=1; rd_last=(beat_cnt==1). On rd_valid & rd_ready: rptr++ and beat_cnt--.
//     Then go FETCH if beat_cnt>1, else IDLE. Without ready, hold; the RAM output must hold when ram_re=0.
// - Throughput is 1 beat per 2 cycles. rptr advances on handshake, so count includes the beat being presented.
// - flush sets flush_pend (sticky). A flush arriving during a burst is serviced after that burst ends.
// - Empty/underflow cannot occur: bursts only start with count >= beat_cnt.
// CONFIGURATION
// - FIFO_CTRL_ERR_EN defined: adds output ovf_err (1 bit, reset 0).
//   ovf_err is sticky, set the cycle after wr_req & full, cleared only by rst_n.
// - FIFO_CTRL_ERR_EN undefined: no ovf_err port; rejected writes are silent (wr_accept=0 only).
// TESTING
// - Reset then idle: count=0, empty=1, ae_flag=1, af_flag=0, rd_valid=0.
// - SIZE=4, BURST=4, rd_ready=1. Write 4 words 0..3:
//   - burst of 4 beats, addresses 0..3; rd_last only on beat 4; count returns to 0.
// - Write 16 words, no reads possible (rd_ready=0):
//   - full=1, af_flag=1 from count=12, 17th wr_req gives wr_accept=0.
//   - With FIFO_CTRL_ERR_EN, ovf_err=1.
// - Write 3 words (< BURST), no burst starts; pulse flush:
//   - one 3-beat burst, rd_last on beat 3, then flush_pend clears and empty=1.
// - Write every cycle while bursting with rd_ready toggling 1/0:
//   - data order preserved; count never exceeds 16; wptr/rptr wrap past 15 correctly.
// - Drop rst_n mid-burst in HOLD:
//   - rd_valid=0 and count=0 immediately (async); FSM IDLE on release.

Source files
------------

// File: rtl/fifo_burst_ctrl.sv
// Pointer/flag controller and BURST-beat read scheduler for a 2**SIZE-entry FIFO on sync-read RAM.
// Optional overflow error flag enabled by defining FIFO_CTRL_ERR_EN.
module fifo_burst_ctrl #(
  parameter int unsigned SIZE      = 4,
  parameter int unsigned BURST     = 4,
  parameter int unsigned AE_THRESH = 10,
  parameter int unsigned AF_THRESH = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_req,
  output logic            wr_accept,
  output logic            ram_we,
  output logic [SIZE-1:0] ram_waddr,
  output logic            ram_re,
  output logic [SIZE-1:0] ram_raddr,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic            rd_last,
  input  logic            flush,
  output logic            full,
  output logic            empty,
  output logic            ae_flag,
  output logic            af_flag,
  output logic [SIZE:0]   count
`ifdef FIFO_CTRL_ERR_EN
  ,
  output logic            ovf_err
`endif
);

  localparam int unsigned   DEPTH   = 1 << SIZE;
  localparam logic [SIZE:0] DEPTH_C = DEPTH[SIZE:0];
  localparam logic [SIZE:0] BURST_C = BURST[SIZE:0];
  localparam logic [SIZE:0] AE_C    = AE_THRESH[SIZE:0];
  localparam logic [SIZE:0] AF_C    = AF_THRESH[SIZE:0];
  localparam logic [SIZE:0] ONE     = {{SIZE{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [SIZE:0] wptr_q, wptr_d;
  logic [SIZE:0] rptr_q, rptr_d;
  logic [SIZE:0] beat_q, beat_d;
  logic          flush_pend_q, flush_pend_d;

  assign count     = wptr_q - rptr_q;
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign ae_flag   = (count < AE_C);
  assign af_flag   = (count >= AF_C);
  assign wr_accept = wr_req & ~full;
  assign ram_we    = wr_accept;
  assign ram_waddr = wptr_q[SIZE-1:0];
  assign ram_raddr = rptr_q[SIZE-1:0];

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    wptr_d       = wr_accept ? (wptr_q + ONE) : wptr_q;
    rptr_d       = rptr_q;
    flush_pend_d = flush_pend_q | flush;
    ram_re       = 1'b0;
    rd_valid     = 1'b0;
    rd_last      = 1'b0;
    case (state_q)
      IDLE: begin
        if (count >= BURST_C) begin
          beat_d  = BURST_C;
          state_d = FETCH;
        end else if (flush_pend_q && !empty) begin
          beat_d  = count;
          state_d = FETCH;
        end else if (flush_pend_q) begin
          // A flush pulse landing on the clearing cycle must still be kept.
          flush_pend_d = flush;
        end
      end
      FETCH: begin
        ram_re  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        rd_valid = 1'b1;
        rd_last  = (beat_q == ONE);
        if (rd_ready) begin
          rptr_d  = rptr_q + ONE;
          beat_d  = beat_q - ONE;
          state_d = (beat_q > ONE) ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (wr_req && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`endif

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Self-checking bench for fifo_burst_ctrl: directed vector table, corner sequences, and
// randomized traffic scored against a queue-based occupancy/burst model.
module tb_fifo_burst_ctrl;
  localparam int SIZE  = 4;
  localparam int DEPTH = 16;
  localparam int BURST = 4;
  localparam int AE    = 10;
  localparam int AF    = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_req = 1'b0, rd_ready = 1'b0, flush = 1'b0;
  logic wr_accept, ram_we, ram_re, rd_valid, rd_last, full, empty, ae_flag, af_flag;
  logic [SIZE-1:0] ram_waddr, ram_raddr;
  logic [SIZE:0]   count;
`ifdef FIFO_CTRL_ERR_EN
  logic ovf_err;
`endif

  fifo_burst_ctrl #(
    .SIZE(SIZE), .BURST(BURST), .AE_THRESH(AE), .AF_THRESH(AF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_accept(wr_accept),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_re(ram_re), .ram_raddr(ram_raddr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last), .flush(flush),
    .full(full), .empty(empty), .ae_flag(ae_flag), .af_flag(af_flag), .count(count)
`ifdef FIFO_CTRL_ERR_EN
    , .ovf_err(ovf_err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural sync-read RAM; output holds while ram_re is low.
  int unsigned mem [DEPTH];
  int unsigned rdata = 0;
  int unsigned wdata = 0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= wdata;
    if (ram_re) rdata <= mem[ram_raddr];
  end

  int checks = 0;
  int failures = 0;

  // Reference model: FIFO contents, pointer counts, beats left in the current burst.
  int unsigned q[$];
  int unsigned wseq = 100;
  int wcnt = 0, rcnt = 0, rem = 0;
  bit fp = 0;
  bit acc_s, hs_s;
  int n_s;
  int beats = 0, lasts = 0, last_idx = 0;

  typedef struct {
    bit wr; bit rdy; bit fl;
    int cnt; bit vld; bit last; bit emp; int raddr;
  } vec_t;
  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rem = 0; fp = 0; wcnt = 0; rcnt = 0;
  endtask

  task automatic drive_check(input bit wr, input bit rdy, input bit fl);
    int n;
    @(negedge clk);
    wr_req = wr; rd_ready = rdy; flush = fl; wdata = wseq;
    #1;
    n = q.size();
    chk("count", count, n);
    chk("empty", empty, n == 0);
    chk("full", full, n == DEPTH);
    chk("ae_flag", ae_flag, n < AE);
    chk("af_flag", af_flag, n >= AF);
    chk("wr_accept", wr_accept, wr && n < DEPTH);
    chk("ram_we", ram_we, wr && n < DEPTH);
    if (wr && n < DEPTH) chk("ram_waddr", ram_waddr, wcnt % DEPTH);
    chk("valid_outside_burst", rd_valid && rem == 0, 0);
    chk("rd_last", rd_last, rd_valid && rem == 1);
    if (rd_valid && rdy) begin
      chk("rd_underflow", n > 0, 1);
      chk("ram_raddr", ram_raddr, rcnt % DEPTH);
      if (n > 0) chk("rdata_order", rdata, q[0]);
      beats++;
      if (rd_last) begin lasts++; last_idx = beats; end
    end
    acc_s = wr && n < DEPTH;
    hs_s  = rd_valid && rdy;
    n_s   = n;
  endtask

  task automatic advance(input bit fl);
    @(posedge clk);
    if (rem == 0) begin
      if (n_s >= BURST) rem = BURST;
      else if (fp && n_s > 0) rem = n_s;
      else if (fp) fp = 0;
    end else if (hs_s) begin
      rem--;
    end
    fp = fp | fl;
    if (acc_s) begin q.push_back(wseq); wseq++; wcnt++; end
    if (hs_s) begin void'(q.pop_front()); rcnt++; end
  endtask

  task automatic step(input bit wr, input bit rdy, input bit fl);
    drive_check(wr, rdy, fl);
    advance(fl);
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      step(0, 1, 0);
      done = (q.size() == 0 && rem == 0);
    end
    chk(name, done, 1);
  endtask

  initial begin
    // write 4 words with ready high: burst of 4 at addresses 0..3, last on beat 4
    vecs[0]  = '{1,1,0, 0,0,0,1, 0};
    vecs[1]  = '{1,1,0, 1,0,0,0, 0};
    vecs[2]  = '{1,1,0, 2,0,0,0, 0};
    vecs[3]  = '{1,1,0, 3,0,0,0, 0};
    vecs[4]  = '{0,1,0, 4,0,0,0, 0};
    vecs[5]  = '{0,1,0, 4,0,0,0, 0};
    vecs[6]  = '{0,1,0, 4,1,0,0, 0};
    vecs[7]  = '{0,1,0, 3,0,0,0, 1};
    vecs[8]  = '{0,1,0, 3,1,0,0, 1};
    vecs[9]  = '{0,1,0, 2,0,0,0, 2};
    vecs[10] = '{0,1,0, 2,1,0,0, 2};
    vecs[11] = '{0,1,0, 1,0,0,0, 3};
    vecs[12] = '{0,1,0, 1,1,1,0, 3};
    vecs[13] = '{0,1,0, 0,0,0,1, 4};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", ae_flag, 1);
    chk("rst_af", af_flag, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_re", ram_re, 0);
`ifdef FIFO_CTRL_ERR_EN
    chk("rst_ovf", ovf_err, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive_check(vecs[i].wr, vecs[i].rdy, vecs[i].fl);
      chk("tbl_count", count, vecs[i].cnt);
      chk("tbl_valid", rd_valid, vecs[i].vld);
      chk("tbl_last", rd_last, vecs[i].last);
      chk("tbl_empty", empty, vecs[i].emp);
      chk("tbl_raddr", ram_raddr, vecs[i].raddr);
      advance(vecs[i].fl);
    end

    // fill to full with consumer stalled; 17th write rejected
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
    drive_check(1, 0, 0);
    chk("full_at_16", full, 1);
    chk("af_at_16", af_flag, 1);
    chk("wr_accept_17th", wr_accept, 0);
    advance(0);
    drive_check(0, 0, 0);
`ifdef FIFO_CTRL_ERR_EN
    chk("ovf_err_set", ovf_err, 1);
`endif
    advance(0);
    drain("drain_after_full");

    // short burst only via flush
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    beats = 0; lasts = 0; last_idx = 0;
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    chk("no_burst_below_burst", beats, 0);
    step(0, 1, 1);
    drain("flush_drain");
    chk("flush_beats", beats, 3);
    chk("flush_lasts", lasts, 1);
    chk("flush_last_idx", last_idx, 3);
    drive_check(0, 1, 0);
    chk("flush_empty", empty, 1);
    advance(0);
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    chk("flush_pend_cleared", beats, 3);
    step(0, 1, 1);
    drain("flush_drain2");

    // randomized traffic: ready toggling, then random
    begin
      bit rdy = 0;
      for (int i = 0; i < 3000; i++) begin
        rdy = (i < 1500) ? ~rdy : bit'($urandom_range(0, 1));
        step($urandom_range(0, 9) < 7, rdy, $urandom_range(0, 63) == 0);
      end
    end
    step(0, 1, 1);
    drain("random_drain");
    chk("ptr_wrapped", rcnt > 2 * DEPTH, 1);

    // async reset while a beat is presented
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    begin
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        drive_check(0, 0, 0);
        seen = rd_valid;
        if (!seen) advance(0);
      end
      chk("hold_reached", seen, 1);
    end
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", rd_valid, 0);
    chk("rstmid_last", rd_last, 0);
    chk("rstmid_count", count, 0);
    chk("rstmid_empty", empty, 1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    beats = 0;
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    chk("no_beats_after_reset", beats, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    drain("post_reset_burst");
    chk("post_reset_beats", beats, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
